// File: rtl/breath_led_multi.sv
// rtl/breath_led_multi.sv - multi-channel breathing/blinking LED PWM driver
//
// Purpose : one shared PWM period counter drives CH LED channels. Each channel
//           owns a duty value that ramps up and down by STEP once per period,
//           and a per-channel mode selects off / on / breath / blink.
// Ports   :
//   sys_clk      in   1         sole clock, rising edge
//   sys_rst_n    in   1         synchronous active-low reset
//   en           in   1         global enable; 0 parks counter and LEDs
//   hold         in   1         freezes duty/flag ramps while 1
//   mode         in   2*CH      per-channel mode [2i+1:2i]: 00 off 01 on 10 breath 11 blink
//   led          out  CH        registered LED drive (polarity per LED_ACT_LOW)
//   period_cnt   out  CNT_W     shared PWM period counter
//   duty_cycle   out  CH*CNT_W  channel i duty at [CNT_W*i +: CNT_W]
//   inc_dec_flag out  CH        per-channel ramp direction, 0 rising, 1 falling
//   period_tick  out  1         high while period_cnt == PERIOD-1 and en == 1
module breath_led_multi #(
    parameter int CH          = 4,
    parameter int CNT_W       = 16,
    parameter int PERIOD      = 50000,
    parameter int STEP        = 25,
    parameter int LED_ACT_LOW = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  en,
    input  logic                  hold,
    input  logic [2*CH-1:0]       mode,
    output logic [CH-1:0]         led,
    output logic [CNT_W-1:0]      period_cnt,
    output logic [CH*CNT_W-1:0]   duty_cycle,
    output logic [CH-1:0]         inc_dec_flag,
    output logic                  period_tick
);

    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_STEP   = CNT_W'(STEP);
    // Rising ramp saturates once duty reaches this, so duty+STEP never
    // exceeds PERIOD and never overflows CNT_W.
    localparam logic [CNT_W-1:0] LP_TOP    = CNT_W'(PERIOD - STEP);
    localparam logic             LP_INACT  = (LED_ACT_LOW != 0);

    // Channels start staggered across the ramp so they do not breathe in phase.
    function automatic logic [CNT_W-1:0] f_init_duty(input int idx);
        return CNT_W'(((idx * (PERIOD / STEP)) / CH) * STEP);
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick      = en && (r_cnt == LP_LAST);
    assign period_tick = w_tick;
    assign period_cnt  = r_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (!en) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_duty;
        logic             r_flag;
        logic             r_led;
        logic             w_pre;

        // Ramps run regardless of mode so switching into breath never jumps.
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                r_duty <= f_init_duty(g);
                r_flag <= 1'b0;
            end else if (w_tick && !hold) begin
                if (!r_flag) begin
                    if (r_duty >= LP_TOP) begin
                        r_duty <= LP_PERIOD;
                        r_flag <= 1'b1;
                    end else begin
                        r_duty <= r_duty + LP_STEP;
                    end
                end else begin
                    if (r_duty <= LP_STEP) begin
                        r_duty <= '0;
                        r_flag <= 1'b0;
                    end else begin
                        r_duty <= r_duty - LP_STEP;
                    end
                end
            end
        end

        always_comb begin
            w_pre = 1'b0;
            case (mode[2*g +: 2])
                2'b00:   w_pre = 1'b0;
                2'b01:   w_pre = 1'b1;
                2'b10:   w_pre = (r_cnt < r_duty);
                default: w_pre = r_flag;
            endcase
        end

        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n || !en) begin
                r_led <= LP_INACT;
            end else begin
                r_led <= w_pre ^ LP_INACT;
            end
        end

        assign duty_cycle[CNT_W*g +: CNT_W] = r_duty;
        assign inc_dec_flag[g]              = r_flag;
        assign led[g]                       = r_led;
    end

endmodule

// File: doc/breath_led_multi.md
BREATH_LED_MULTI -- requirements
Module: breath_led_multi

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the period counter and each duty value.
REQ-003 SHALL have parameter PERIOD, default 50000, meaning PWM period in sys_clk cycles (2..2^CNT_W-1).
REQ-004 SHALL have parameter STEP, default 25, meaning duty change per PWM period (1..PERIOD).
REQ-005 SHALL have parameter LED_ACT_LOW, default 0, meaning 1 inverts every led bit at the output.
REQ-006 SHALL have port sys_clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port sys_rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port en  input  1  global enable; 0 parks the block.
REQ-009 SHALL have port hold  input  1  freezes all duty/flag ramps while 1.
REQ-010 SHALL have port mode  input  2*CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 on, 10 breath, 11 blink.
REQ-011 SHALL have port led  output  CH  registered LED drive per channel.
REQ-012 SHALL have port period_cnt  output  CNT_W  shared PWM period counter.
REQ-013 SHALL have port duty_cycle  output  CH*CNT_W  channel i duty at [CNT_W*i +: CNT_W].
REQ-014 SHALL have port inc_dec_flag  output  CH  per-channel ramp direction, 0 rising, 1 falling.
REQ-015 SHALL have port period_tick  output  1  combinational, high while period_cnt == PERIOD-1 and en == 1.

Function
REQ-016 period_cnt SHALL increment by 1 each cycle while en=1 and wrap from PERIOD-1 to 0.
REQ-017 While en=0, period_cnt SHALL be loaded with 0, duty/flag SHALL hold, and all led bits SHALL be inactive (0, or 1 if LED_ACT_LOW).
REQ-018 Duty/flag of every channel SHALL update only on the edge where period_tick=1 and hold=0.
REQ-019 Rising update (flag=0): if duty >= PERIOD-STEP then duty<=PERIOD and flag<=1, else duty<=duty+STEP.
REQ-020 Falling update (flag=1): if duty <= STEP then duty<=0 and flag<=0, else duty<=duty-STEP.
REQ-021 Duty SHALL never leave [0, PERIOD]; arithmetic SHALL be done without CNT_W overflow.
REQ-022 Ramps SHALL run in all modes so that a mode change never causes a duty discontinuity.
REQ-023 Pre-polarity led[i] SHALL be registered from: 00 -> 0; 01 -> 1; 10 -> (period_cnt < duty_i); 11 -> inc_dec_flag[i]; latency 1 cycle from period_cnt value to led.
REQ-024 duty=0 SHALL give led constantly off, duty=PERIOD constantly on, in breath mode.
REQ-025 mode and hold changes SHALL take effect on the next rising edge, with no other internal state disturbed.

Reset
REQ-026 On sys_clk edge with sys_rst_n=0: period_cnt<=0, led<=inactive, inc_dec_flag<=0, duty_i<=((i*(PERIOD/STEP))/CH)*STEP (integer division, elaboration-time), regardless of en/hold/mode.
REQ-027 Reset asserted mid-ramp SHALL restore REQ-026 values on the same edge; first period_cnt increment occurs on the first edge after release with en=1.

Verification (CH=2, PERIOD=10, STEP=2, LED_ACT_LOW=0 unless stated)
REQ-028 Reset: sys_rst_n=0 two cycles -> period_cnt=0, duty0=0, duty1=4, inc_dec_flag=00, led=00.
REQ-029 Ramp: en=1, hold=0, ch0 breath -> duty0 per period 0,2,4,6,8,10 (flag0 goes 1 on the 10 update), then 8,6,4,2,0 (flag0 goes 0 on the 0 update); period_tick every 10 cycles.
REQ-030 PWM: duty1=4, mode1=10 -> led[1] high exactly 4 of 10 cycles, rising one cycle after period_cnt=0.
REQ-031 Modes/hold: mode0=00 -> led[0]=0; 01 -> 1; 11 -> led[0] follows flag0; hold=1 across 3 periods -> duty/flags unchanged, period_cnt still wraps.
REQ-032 Enable/reset mid-run: en=0 -> period_cnt=0, led=00, duty frozen, resume from same duty on en=1; sys_rst_n=0 at duty0=6 -> REQ-028 values next edge; LED_ACT_LOW=1 -> led bits inverted in all above.
